// File: rtl/led_pattern_gen.sv
// LED pattern source for the 3x14 charlieplexed matrix: fade/hold/chase animation with frame-rate PWM.
// Optional gamma correction is enabled by defining LED_PATTERN_GAMMA_EN.

module led_pattern_gen #(
    parameter int unsigned FADE_DIV     = 4,
    parameter int unsigned HOLD_FRAMES  = 64,
    parameter int unsigned PAUSE_FRAMES = 32,
    parameter int unsigned CHASE_DIV    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       frame_tick,
    input  logic       scan_valid,
    input  logic [1:0] scan_row,
    input  logic [3:0] scan_col,
    output logic       px_on,
    output logic [2:0] anim_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FADE_IN  = 3'd1,
        ST_HOLD     = 3'd2,
        ST_FADE_OUT = 3'd3,
        ST_PAUSE    = 3'd4
    } state_e;

    localparam logic [7:0] FADE_LAST  = 8'(FADE_DIV - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
    localparam logic [7:0] CHASE_LAST = 8'(CHASE_DIV - 1);

    state_e     state_q, state_d;
    logic [3:0] level_q, level_d;
    logic [3:0] phase_q, phase_d;
    logic [7:0] div_q,   div_d;
    logic [7:0] chase_q, chase_d;
    logic [3:0] pos_q,   pos_d;
    logic       px_q,    px_d;

    logic [3:0] eff_level;
    logic [3:0] gamma_level;
    logic       slot_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            level_q <= 4'd0;
            phase_q <= 4'd0;
            div_q   <= 8'd0;
            chase_q <= 8'd0;
            pos_q   <= 4'd1;
            px_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            chase_q <= chase_d;
            pos_q   <= pos_d;
            px_q    <= px_d;
        end
    end

    // Animation sequencer: en low wins immediately, otherwise everything advances only on frame_tick.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        div_d   = div_q;
        chase_d = chase_q;
        pos_d   = pos_q;
        phase_d = frame_tick ? phase_q + 4'd1 : phase_q;

        if (!en) begin
            state_d = ST_IDLE;
            level_d = 4'd0;
            div_d   = 8'd0;
            chase_d = 8'd0;
            pos_d   = 4'd1;
        end else if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FADE_IN;
                    level_d = 4'd0;
                    div_d   = 8'd0;
                end
                ST_FADE_IN: begin
                    if (div_q == FADE_LAST) begin
                        div_d   = 8'd0;
                        level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                        if (level_q >= 4'd14) begin
                            state_d = ST_HOLD;
                            chase_d = 8'd0;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                ST_HOLD: begin
                    level_d = 4'd15;
                    if (chase_q == CHASE_LAST) begin
                        chase_d = 8'd0;
                        pos_d   = (pos_q >= 4'd14) ? 4'd1 : pos_q + 4'd1;
                    end else begin
                        chase_d = chase_q + 8'd1;
                    end
                    if (div_q == HOLD_LAST) begin
                        div_d   = 8'd0;
                        state_d = ST_FADE_OUT;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                ST_FADE_OUT: begin
                    if (div_q == FADE_LAST) begin
                        div_d   = 8'd0;
                        level_d = (level_q == 4'd0) ? 4'd0 : level_q - 4'd1;
                        if (level_q <= 4'd1) begin
                            state_d = ST_PAUSE;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                ST_PAUSE: begin
                    level_d = 4'd0;
                    if (div_q == PAUSE_LAST) begin
                        div_d   = 8'd0;
                        state_d = ST_FADE_IN;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = 4'd0;
                    div_d   = 8'd0;
                    chase_d = 8'd0;
                    pos_d   = 4'd1;
                end
            endcase
        end
    end

    // In HOLD the chase column runs at full brightness over a half-bright background.
    always_comb begin
        eff_level = level_q;
        if (state_q == ST_HOLD) begin
            eff_level = (scan_col == pos_q) ? 4'd15 : 4'd8;
        end
    end

`ifdef LED_PATTERN_GAMMA_EN
    always_comb begin
        gamma_level = 4'd0;
        case (eff_level)
            4'd0:    gamma_level = 4'd0;
            4'd1:    gamma_level = 4'd0;
            4'd2:    gamma_level = 4'd0;
            4'd3:    gamma_level = 4'd1;
            4'd4:    gamma_level = 4'd1;
            4'd5:    gamma_level = 4'd1;
            4'd6:    gamma_level = 4'd2;
            4'd7:    gamma_level = 4'd2;
            4'd8:    gamma_level = 4'd3;
            4'd9:    gamma_level = 4'd4;
            4'd10:   gamma_level = 4'd5;
            4'd11:   gamma_level = 4'd6;
            4'd12:   gamma_level = 4'd8;
            4'd13:   gamma_level = 4'd10;
            4'd14:   gamma_level = 4'd12;
            default: gamma_level = 4'd15;
        endcase
    end
`else
    assign gamma_level = eff_level;
`endif

    // Row 3 and columns 0/15 have no LED behind them.
    assign slot_ok = scan_valid && (scan_row != 2'd3) && (scan_col != 4'd0) && (scan_col != 4'd15);
    assign px_d    = slot_ok && (gamma_level > phase_q);

    assign px_on      = px_q;
    assign anim_state = state_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed testbench for led_pattern_gen with default parameters; expected values come from
// hand-derived closed-form timelines of the animation (t = frame ticks since reset).

module tb_led_pattern_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       frame_tick;
    logic       scan_valid;
    logic [1:0] scan_row;
    logic [3:0] scan_col;
    logic       px_on;
    logic [2:0] anim_state;

    int totalChecks = 0;
    int badChecks   = 0;
    int tickCount   = 0;

    led_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .frame_tick (frame_tick),
        .scan_valid (scan_valid),
        .scan_row   (scan_row),
        .scan_col   (scan_col),
        .px_on      (px_on),
        .anim_state (anim_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("[TB] FAIL %s t=%0d: observed=%0d expected=%0d", tag, tickCount, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] r, input logic [3:0] c, input logic ft);
        scan_valid = v;
        scan_row   = r;
        scan_col   = c;
        frame_tick = ft;
    endtask

    // Timeline: FADE_IN ticks 1..60, HOLD from 61, then a 216-tick cycle HOLD/FADE_OUT/PAUSE/FADE_IN.
    function automatic int expState(input int t);
        int m;
        if (t == 0) return 0;
        if (t <= 60) return 1;
        m = (t - 61) % 216;
        if (m < 64)  return 2;
        if (m < 124) return 3;
        if (m < 156) return 4;
        return 1;
    endfunction

    function automatic int expLevel(input int t);
        int m;
        if (t == 0) return 0;
        if (t <= 60) return (t - 1) / 4;
        m = (t - 61) % 216;
        if (m < 64)  return 15;
        if (m < 124) return 15 - (m - 64) / 4;
        if (m < 156) return 0;
        return (m - 156) / 4;
    endfunction

    // Each HOLD makes 8 chase advances (every 8th tick, including the exit tick).
    function automatic int expPos(input int t);
        int n, m, adv;
        if (t < 61) return 1;
        n   = (t - 61) / 216;
        m   = (t - 61) % 216;
        adv = 8 * n + ((m < 64) ? (m / 8) : 8);
        return (adv % 14) + 1;
    endfunction

    function automatic int gammaOf(input int e);
`ifdef LED_PATTERN_GAMMA_EN
        int tbl [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
        return tbl[e];
`else
        return e;
`endif
    endfunction

    function automatic int expPx(input int t, input logic v, input int r, input int c);
        int e;
        if (!v || r == 3 || c == 0 || c == 15) return 0;
        if (expState(t) == 2) e = (c == expPos(t)) ? 15 : 8;
        else e = expLevel(t);
        return (gammaOf(e) > (t % 16)) ? 1 : 0;
    endfunction

    // One frame: a rotating probe shares the tick cycle (sees pre-tick values), then the chase column is probed.
    task automatic doTick();
        logic       vA;
        logic [1:0] rA;
        logic [3:0] cA;
        logic [1:0] rB;
        logic [3:0] cB;
        vA = ((tickCount % 7) != 0);
        rA = 2'((tickCount / 16) % 4);
        cA = 4'(tickCount % 16);
        applyStimulus(vA, rA, cA, 1'b1);
        @(negedge clk);
        tickCount++;
        checkOutput("px_pre_tick", int'(px_on), expPx(tickCount - 1, vA, int'(rA), int'(cA)));
        checkOutput("anim_state", int'(anim_state), expState(tickCount));
        rB = 2'(tickCount % 3);
        cB = 4'(expPos(tickCount));
        applyStimulus(1'b1, rB, cB, 1'b0);
        @(negedge clk);
        checkOutput("px_chase_col", int'(px_on), expPx(tickCount, 1'b1, int'(rB), int'(cB)));
    endtask

    task automatic runTicks(input int upto);
        while (tickCount < upto) doTick();
    endtask

    task automatic probeOff(input string tag, input logic v, input logic [1:0] r, input logic [3:0] c);
        applyStimulus(v, r, c, 1'b0);
        @(negedge clk);
        checkOutput(tag, int'(px_on), 0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_state", int'(anim_state), 0);
        checkOutput("reset_px", int'(px_on), 0);
        rst = 1'b0;
        probeOff("idle_probe", 1'b1, 2'd0, 4'd5);

        // Full first cycle plus the second HOLD (chase wrap 14->1) and into FADE_OUT.
        en = 1'b1;
        runTicks(360);
        checkOutput("fade_out_reached", int'(anim_state), 3);

        // Dropping en with no tick forces IDLE on the next edge.
        en = 1'b0;
        applyStimulus(1'b0, 2'd0, 4'd5, 1'b0);
        @(negedge clk);
        checkOutput("en_drop_state", int'(anim_state), 0);
        probeOff("en_drop_px_a", 1'b1, 2'd0, 4'd5);
        probeOff("en_drop_px_b", 1'b1, 2'd1, 4'd1);
        probeOff("en_drop_px_c", 1'b1, 2'd2, 4'd14);
        applyStimulus(1'b1, 2'd0, 4'd7, 1'b1);
        @(negedge clk);
        checkOutput("idle_tick_en0", int'(anim_state), 0);
        checkOutput("idle_tick_px", int'(px_on), 0);

        // Fresh start, run into HOLD, then probe the invalid slots.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tickCount = 0;
        en = 1'b1;
        runTicks(66);
        probeOff("hold_col0", 1'b1, 2'd0, 4'd0);
        probeOff("hold_col15", 1'b1, 2'd1, 4'd15);
        probeOff("hold_row3", 1'b1, 2'd3, 4'd1);
        probeOff("hold_invalid", 1'b0, 2'd0, 4'd1);
        applyStimulus(1'b1, 2'd0, 4'd1, 1'b0);
        @(negedge clk);
        checkOutput("hold_lit_before_rst", int'(px_on), 1);

        // Asynchronous reset mid-cycle clears outputs before the next clock edge.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_state", int'(anim_state), 0);
        checkOutput("async_rst_px", int'(px_on), 0);
        @(negedge clk);
        rst = 1'b0;
        tickCount = 0;
        runTicks(61);
        checkOutput("restart_hold", int'(anim_state), 2);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
